// File: rtl/fifo_ptr_ctrl.sv
// Longword FIFO with write/read pointers, byte offset and status flags for the SCSI engine.
// Each storage entry is its own instance; bytes pack big-endian, with lane BO=0 at [31:24].

module fifo_ptr_ctrl_entry (
  input  logic        nCLK,
  input  logic        CRESET_,
  input  logic        we_lw,
  input  logic        we_byte,
  input  logic [1:0]  bo,
  input  logic [31:0] wr_data,
  input  logic [7:0]  byte_in,
  output logic [31:0] q
);

  // Lane l holds bits [8l+7:8l], so BO addresses lane 3-BO.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic lane_hit;
    assign lane_hit = we_byte && (bo == 2'(3 - l));

    always_ff @(posedge nCLK or negedge CRESET_) begin
      if (!CRESET_)      q[l*8 +: 8] <= 8'h00;
      else if (we_lw)    q[l*8 +: 8] <= wr_data[l*8 +: 8];
      else if (lane_hit) q[l*8 +: 8] <= byte_in;
    end
  end

endmodule

module fifo_ptr_ctrl #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  nCLK,
  input  logic                  CRESET_,
  input  logic                  FLUSH,
  input  logic                  INCFIFO,
  input  logic                  DECFIFO,
  input  logic                  INCNI,
  input  logic                  INCNO,
  input  logic                  INCBO,
  input  logic                  WR_LW,
  input  logic [31:0]           WR_DATA,
  input  logic                  WR_BYTE,
  input  logic [7:0]            BYTE_IN,
  output logic [31:0]           RD_DATA,
  output logic [7:0]            BYTE_OUT,
  output logic [1:0]            BO,
  output logic                  BOEQ3,
  output logic [DEPTH_LOG2-1:0] WRPTR,
  output logic [DEPTH_LOG2-1:0] RDPTR,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  FIFOFULL,
  output logic                  FIFOEMPTY,
  output logic                  OVF,
  output logic                  UNF
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DEPTH-1:0][31:0] mem_q;

  // FLUSH suppresses every other strobe, writes included.
  logic wr_lw_en, wr_byte_en;
  assign wr_lw_en   = WR_LW   & ~FLUSH;
  assign wr_byte_en = WR_BYTE & ~FLUSH;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic sel;
    assign sel = (WRPTR == DEPTH_LOG2'(e));

    fifo_ptr_ctrl_entry u_ent (
      .nCLK    (nCLK),
      .CRESET_ (CRESET_),
      .we_lw   (wr_lw_en & sel),
      .we_byte (wr_byte_en & sel),
      .bo      (BO),
      .wr_data (WR_DATA),
      .byte_in (BYTE_IN),
      .q       (mem_q[e])
    );
  end

  assign RD_DATA = mem_q[RDPTR];

  always_comb begin
    BYTE_OUT = RD_DATA[31:24];
    case (BO)
      2'd1:    BYTE_OUT = RD_DATA[23:16];
      2'd2:    BYTE_OUT = RD_DATA[15:8];
      2'd3:    BYTE_OUT = RD_DATA[7:0];
      default: BYTE_OUT = RD_DATA[31:24];
    endcase
  end

  assign FIFOFULL  = (COUNT == FULL_CNT);
  assign FIFOEMPTY = (COUNT == '0);
  assign BOEQ3     = (BO == 2'd3);

  logic [DEPTH_LOG2-1:0] wrptr_d, rdptr_d;
  logic [DEPTH_LOG2:0]   count_d;
  logic [1:0]            bo_d;
  logic                  ovf_d, unf_d;

  always_comb begin
    wrptr_d = WRPTR;
    rdptr_d = RDPTR;
    count_d = COUNT;
    bo_d    = BO;
    ovf_d   = OVF;
    unf_d   = UNF;
    if (FLUSH) begin
      wrptr_d = '0;
      rdptr_d = '0;
      count_d = '0;
      bo_d    = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (INCNI) wrptr_d = WRPTR + DEPTH_LOG2'(1);
      if (INCNO) rdptr_d = RDPTR + DEPTH_LOG2'(1);
      if (INCBO) bo_d    = BO + 2'd1;
      // Simultaneous add and remove leaves the count and error flags untouched.
      if (INCFIFO && !DECFIFO) begin
        if (FIFOFULL) ovf_d   = 1'b1;
        else          count_d = COUNT + (DEPTH_LOG2 + 1)'(1);
      end else if (DECFIFO && !INCFIFO) begin
        if (FIFOEMPTY) unf_d   = 1'b1;
        else           count_d = COUNT - (DEPTH_LOG2 + 1)'(1);
      end
    end
  end

  always_ff @(posedge nCLK or negedge CRESET_) begin
    if (!CRESET_) begin
      WRPTR <= '0;
      RDPTR <= '0;
      COUNT <= '0;
      BO    <= '0;
      OVF   <= 1'b0;
      UNF   <= 1'b0;
    end else begin
      WRPTR <= wrptr_d;
      RDPTR <= rdptr_d;
      COUNT <= count_d;
      BO    <= bo_d;
      OVF   <= ovf_d;
      UNF   <= unf_d;
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed scenarios plus randomized strobes for fifo_ptr_ctrl, checked against an array/arithmetic model.
module tb_fifo_ptr_ctrl;

  localparam int DEPTH = 8;

  logic        nCLK = 1'b0;
  logic        CRESET_ = 1'b0;
  logic        FLUSH = 0, INCFIFO = 0, DECFIFO = 0, INCNI = 0, INCNO = 0, INCBO = 0;
  logic        WR_LW = 0, WR_BYTE = 0;
  logic [31:0] WR_DATA = '0;
  logic [7:0]  BYTE_IN = '0;
  logic [31:0] RD_DATA;
  logic [7:0]  BYTE_OUT;
  logic [1:0]  BO;
  logic        BOEQ3, FIFOFULL, FIFOEMPTY, OVF, UNF;
  logic [2:0]  WRPTR, RDPTR;
  logic [3:0]  COUNT;

  fifo_ptr_ctrl #(.DEPTH_LOG2(3)) dut (
    .nCLK(nCLK), .CRESET_(CRESET_), .FLUSH(FLUSH), .INCFIFO(INCFIFO), .DECFIFO(DECFIFO),
    .INCNI(INCNI), .INCNO(INCNO), .INCBO(INCBO), .WR_LW(WR_LW), .WR_DATA(WR_DATA),
    .WR_BYTE(WR_BYTE), .BYTE_IN(BYTE_IN), .RD_DATA(RD_DATA), .BYTE_OUT(BYTE_OUT),
    .BO(BO), .BOEQ3(BOEQ3), .WRPTR(WRPTR), .RDPTR(RDPTR), .COUNT(COUNT),
    .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY), .OVF(OVF), .UNF(UNF)
  );

  always #5 nCLK = ~nCLK;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_mem [DEPTH];
  int m_wp, m_rp, m_bo, m_cnt;
  bit m_ovf, m_unf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear(input bit wipe_mem);
    m_wp = 0; m_rp = 0; m_bo = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    if (wipe_mem) for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endfunction

  // Behaviour from the rules: writes use pre-edge WRPTR/BO, count saturates with sticky errors.
  function automatic void model_edge();
    if (FLUSH) begin
      model_clear(0);
      return;
    end
    if (WR_LW)        m_mem[m_wp] = WR_DATA;
    else if (WR_BYTE) m_mem[m_wp][8*(3-m_bo) +: 8] = BYTE_IN;
    if (INCFIFO && !DECFIFO) begin
      if (m_cnt == DEPTH) m_ovf = 1; else m_cnt++;
    end else if (DECFIFO && !INCFIFO) begin
      if (m_cnt == 0) m_unf = 1; else m_cnt--;
    end
    if (INCNI) m_wp = (m_wp + 1) % DEPTH;
    if (INCNO) m_rp = (m_rp + 1) % DEPTH;
    if (INCBO) m_bo = (m_bo + 1) % 4;
  endfunction

  task automatic check_all(input string p);
    logic [31:0] rd;
    rd = m_mem[m_rp];
    chk({p, ".rd"},    RD_DATA,   rd);
    chk({p, ".bout"},  BYTE_OUT,  rd[8*(3-m_bo) +: 8]);
    chk({p, ".bo"},    BO,        m_bo);
    chk({p, ".boeq3"}, BOEQ3,     m_bo == 3);
    chk({p, ".wp"},    WRPTR,     m_wp);
    chk({p, ".rp"},    RDPTR,     m_rp);
    chk({p, ".cnt"},   COUNT,     m_cnt);
    chk({p, ".full"},  FIFOFULL,  m_cnt == DEPTH);
    chk({p, ".empty"}, FIFOEMPTY, m_cnt == 0);
    chk({p, ".ovf"},   OVF,       m_ovf);
    chk({p, ".unf"},   UNF,       m_unf);
  endtask

  // Inputs are driven after a falling edge, applied at the rising edge, checked at the next falling edge.
  task automatic step(input string p, input logic fl, incf, decf, ni, no, ib, wl,
                      input logic [31:0] wd, input logic wb, input logic [7:0] bi);
    FLUSH = fl; INCFIFO = incf; DECFIFO = decf; INCNI = ni; INCNO = no; INCBO = ib;
    WR_LW = wl; WR_DATA = wd; WR_BYTE = wb; BYTE_IN = bi;
    @(posedge nCLK);
    model_edge();
    @(negedge nCLK);
    FLUSH = 0; INCFIFO = 0; DECFIFO = 0; INCNI = 0; INCNO = 0; INCBO = 0;
    WR_LW = 0; WR_BYTE = 0;
    check_all(p);
  endtask

  task automatic mid_reset(input string p);
    #2 CRESET_ = 1'b0;
    #1 model_clear(1);
    check_all({p, ".low"});
    @(negedge nCLK);
    check_all({p, ".hold"});
    CRESET_ = 1'b1;
    @(negedge nCLK);
    check_all({p, ".rel"});
  endtask

  initial begin
    logic [7:0] pk [4];
    pk[0] = 8'hDE; pk[1] = 8'hAD; pk[2] = 8'hBE; pk[3] = 8'hEF;
    model_clear(1);
    repeat (2) @(negedge nCLK);
    check_all("rst0");
    CRESET_ = 1'b1;
    @(negedge nCLK);

    // Fill eight entries, then overflow.
    for (int k = 1; k <= 8; k++)
      step("fill", 0, 1, 0, 1, 0, 0, 1, 32'h11111111 * k, 0, 8'h00);
    chk("fill_full", FIFOFULL, 1'b1);
    chk("fill_wrptr", WRPTR, 3'd0);
    step("ovf", 0, 1, 0, 0, 0, 0, 0, '0, 0, 8'h00);
    chk("ovf_set", OVF, 1'b1);
    chk("ovf_cnt", COUNT, 4'd8);

    // Pack a longword into entry 0 byte by byte.
    for (int i = 0; i < 4; i++) begin
      step("pack", 0, 0, 0, 0, 0, 1, 0, '0, 1, pk[i]);
      if (i == 2) chk("pack_boeq3", BOEQ3, 1'b1);
    end
    chk("pack_bo", BO, 2'd0);
    chk("pack_word", RD_DATA, 32'hDEADBEEF);

    // Drain in write order and underflow.
    for (int k = 0; k < 8; k++) begin
      chk("drain_data", RD_DATA, (k == 0) ? 32'hDEADBEEF : 32'h11111111 * (k + 1));
      step("drain", 0, 0, 1, 0, 1, 0, 0, '0, 0, 8'h00);
    end
    chk("drain_rp", RDPTR, 3'd0);
    chk("drain_empty", FIFOEMPTY, 1'b1);
    step("unf", 0, 0, 1, 0, 0, 0, 0, '0, 0, 8'h00);
    chk("unf_set", UNF, 1'b1);
    chk("unf_cnt", COUNT, 4'd0);

    // Simultaneous INCFIFO/DECFIFO at 0, 4 and 8.
    step("clr", 1, 0, 0, 0, 0, 0, 0, '0, 0, 8'h00);
    step("both0", 0, 1, 1, 0, 0, 0, 0, '0, 0, 8'h00);
    chk("both0_unf", UNF, 1'b0);
    repeat (4) step("inc", 0, 1, 0, 0, 0, 0, 0, '0, 0, 8'h00);
    step("both4", 0, 1, 1, 0, 0, 0, 0, '0, 0, 8'h00);
    chk("both4_cnt", COUNT, 4'd4);
    repeat (4) step("inc", 0, 1, 0, 0, 0, 0, 0, '0, 0, 8'h00);
    step("both8", 0, 1, 1, 0, 0, 0, 0, '0, 0, 8'h00);
    chk("both8_ovf", OVF, 1'b0);

    // Flush mid-transfer: COUNT=5, BO=2, OVF=1, with a write and INCFIFO alongside.
    step("ovf2", 0, 1, 0, 0, 0, 0, 0, '0, 0, 8'h00);
    repeat (3) step("dec", 0, 0, 1, 0, 0, 0, 0, '0, 0, 8'h00);
    repeat (2) step("bo", 0, 0, 0, 0, 0, 1, 0, '0, 0, 8'h00);
    chk("pre_flush_cnt", COUNT, 4'd5);
    step("flush", 1, 1, 0, 1, 1, 1, 1, 32'hCAFEF00D, 1, 8'h55);
    chk("flush_cnt", COUNT, 4'd0);
    chk("flush_empty", FIFOEMPTY, 1'b1);
    chk("flush_keep", RD_DATA, 32'hDEADBEEF);

    // Randomized strobes.
    for (int n = 0; n < 600; n++) begin
      step("rnd", $urandom_range(0, 31) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 2) == 0, 8'($urandom));
      if (n == 300) mid_reset("rst_mid");
    end
    mid_reset("rst_end");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
